reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Tomasulo reservation station: consumer of the register file's read ports.
//  Takes an issued op with operand pairs (dep, data) from the register file,
//  allocates an entry, and returns the entry's tag for the register file's depW.
//  Snoops the CDB to resolve pending operands and dispatches ready ops to one FU.
//  Frees an entry when its own tag is broadcast on the CDB.
// PARAMETERS
//  DATA_W       16  operand/result width
//  TAG_W        3   dependency tag width; tag 0 = "no dependency"
//  ENTRIES      2   number of entries (1..4)
//  RS_BASE_TAG  1   tag of entry 0; entry i owns tag RS_BASE_TAG+i (must be >0, fit TAG_W)
// PORTS
//  CLK          in   1       clock, rising edge
//  CLR          in   1       reset, asynchronous, active-high
//  issue_valid  in   1       issue stage presents an op
//  issue_ready  out  1       at least one FREE entry (registered state only)
//  issue_op     in   3       FU opcode
//  issue_depA   in   TAG_W   operand A tag from register file (0 = dataA valid)
//  issue_dataA  in   DATA_W  operand A value
//  issue_depB   in   TAG_W   operand B tag
//  issue_dataB  in   DATA_W  operand B value
//  issue_tag    out  TAG_W   tag of entry to be allocated; 0 when !issue_ready
//  cdb_valid    in   1       CDB broadcast valid
//  cdb_tag      in   TAG_W   producer tag on CDB
//  cdb_data     in   DATA_W  result on CDB
//  exec_valid   out  1       dispatch register holds an op
//  exec_ready   in   1       FU accepts
//  exec_op      out  3       dispatched opcode
//  exec_a       out  DATA_W  dispatched operand A
//  exec_b       out  DATA_W  dispatched operand B
//  exec_tag     out  TAG_W   tag of dispatched entry (FU broadcasts it on CDB)
//  busy_count   out  3       number of non-FREE entries
// BEHAVIOUR
//  Reset: all entries FREE, all operand tags/data 0; exec_valid=0, exec_op/a/b/tag=0;
//   busy_count=0; issue_ready=1, issue_tag=RS_BASE_TAG. CLR mid-operation drops all state.
//  Entry states: FREE -> WAIT (any operand tag!=0) or READY (both tags 0) on issue;
//   WAIT -> READY when last pending tag captured; READY -> SENT on load into dispatch reg;
//   SENT -> FREE when cdb_valid && cdb_tag==own tag.
//  Issue: transfer when issue_valid && issue_ready; goes to lowest-index FREE entry.
//   Entry freed this cycle is not reusable until next cycle.
//  Issue-cycle bypass: if cdb_valid && cdb_tag!=0 && cdb_tag==issue_depX, store
//   cdb_data and tag 0 for that operand (no lost wakeup).
//  CDB snoop: every cycle, each WAIT entry with depX==cdb_tag (cdb_valid, tag!=0)
//   captures cdb_data into dataX and clears depX. Both operands may resolve at once.
//   cdb_tag==0 ignored.
//  Dispatch reg: loads when (!exec_valid || exec_ready); source = lowest-index READY
//   entry at start of cycle (entry -> SENT). Entry turning READY appears on exec_*
//   no earlier than next cycle. exec_* hold stable while exec_valid && !exec_ready.
//   Accept with no READY entry -> exec_valid=0 next cycle.
//  CDB of own tag while entry still READY/WAIT: illegal, ignored.
//  busy_count and issue_ready reflect registered state (no same-cycle forwarding).
//  Arithmetic: none on data; tags compared full TAG_W bits.
// TESTING
//  1 Reset, issue op=2 depA=0 dataA=5 depB=0 dataB=7 -> issue_tag=1; next cycle
//    exec_valid=1 exec_a=5 exec_b=7 exec_tag=1; CDB tag 1 -> busy_count 0.
//  2 Issue depA=3 (dataA x); 3 cycles later CDB tag3 data=0x00AA -> entry READY,
//    dispatch next cycle with exec_a=0x00AA.
//  3 Issue depA=4 with cdb_valid tag=4 data=9 same cycle -> dispatch next cycle, exec_a=9.
//  4 Fill both entries -> issue_ready=0, issue_tag=0; issue_valid held -> no allocation;
//    CDB frees tag 2 -> issue_ready=1, issue_tag=2 following cycle.
//  5 Two READY entries, exec_ready=0 for 4 cycles -> exec_tag=1 stable; accept -> tag 2 next.
//  6 Assert CLR while WAIT + SENT entries exist -> all outputs at reset values immediately.

Source files
------------

// File: rtl/reservation_station.sv
// Tomasulo reservation station: allocates entries for issued ops, snoops the CDB
// for pending operands and dispatches ready ops into a single FU dispatch register.
module reservation_station #(
    parameter int DATA_W      = 16,
    parameter int TAG_W       = 3,
    parameter int ENTRIES     = 2,
    parameter int RS_BASE_TAG = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_op,
    input  logic [TAG_W-1:0]  issue_depA,
    input  logic [DATA_W-1:0] issue_dataA,
    input  logic [TAG_W-1:0]  issue_depB,
    input  logic [DATA_W-1:0] issue_dataB,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              exec_valid,
    input  logic              exec_ready,
    output logic [2:0]        exec_op,
    output logic [DATA_W-1:0] exec_a,
    output logic [DATA_W-1:0] exec_b,
    output logic [TAG_W-1:0]  exec_tag,
    output logic [2:0]        busy_count
);

    typedef enum logic [1:0] {
        S_FREE,
        S_WAIT,
        S_READY,
        S_SENT
    } st_e;

    st_e               st_q    [ENTRIES];
    st_e               st_d    [ENTRIES];
    logic [2:0]        op_q    [ENTRIES];
    logic [2:0]        op_d    [ENTRIES];
    logic [TAG_W-1:0]  depa_q  [ENTRIES];
    logic [TAG_W-1:0]  depa_d  [ENTRIES];
    logic [TAG_W-1:0]  depb_q  [ENTRIES];
    logic [TAG_W-1:0]  depb_d  [ENTRIES];
    logic [DATA_W-1:0] dataa_q [ENTRIES];
    logic [DATA_W-1:0] dataa_d [ENTRIES];
    logic [DATA_W-1:0] datab_q [ENTRIES];
    logic [DATA_W-1:0] datab_d [ENTRIES];

    logic              ev_q, ev_d;
    logic [2:0]        eop_q, eop_d;
    logic [DATA_W-1:0] ea_q, ea_d;
    logic [DATA_W-1:0] eb_q, eb_d;
    logic [TAG_W-1:0]  etag_q, etag_d;

    logic               any_free;
    logic               any_rdy;
    logic [ENTRIES-1:0] free_oh;
    logic [ENTRIES-1:0] rdy_oh;
    logic [TAG_W-1:0]   free_tag;
    logic [2:0]         cnt;

    logic              issue_fire;
    logic              load;
    logic              cdb_hit;
    logic              byp_a, byp_b;
    logic [TAG_W-1:0]  in_depa, in_depb;
    logic [DATA_W-1:0] in_dataa, in_datab;

    // Scanning high to low leaves the lowest-index match selected.
    always_comb begin
        any_free = 1'b0;
        any_rdy  = 1'b0;
        free_oh  = '0;
        rdy_oh   = '0;
        free_tag = '0;
        cnt      = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (st_q[i] == S_FREE) begin
                any_free   = 1'b1;
                free_oh    = '0;
                free_oh[i] = 1'b1;
                free_tag   = TAG_W'(RS_BASE_TAG + i);
            end
            if (st_q[i] == S_READY) begin
                any_rdy   = 1'b1;
                rdy_oh    = '0;
                rdy_oh[i] = 1'b1;
            end
            cnt = cnt + {2'b00, st_q[i] != S_FREE};
        end
    end

    assign issue_fire = issue_valid && any_free;
    assign load       = !ev_q || exec_ready;
    assign cdb_hit    = cdb_valid && (cdb_tag != '0);
    assign byp_a      = cdb_hit && (cdb_tag == issue_depA);
    assign byp_b      = cdb_hit && (cdb_tag == issue_depB);
    assign in_depa    = byp_a ? '0 : issue_depA;
    assign in_depb    = byp_b ? '0 : issue_depB;
    assign in_dataa   = byp_a ? cdb_data : issue_dataA;
    assign in_datab   = byp_b ? cdb_data : issue_dataB;

    always_comb begin
        ev_d   = ev_q;
        eop_d  = eop_q;
        ea_d   = ea_q;
        eb_d   = eb_q;
        etag_d = etag_q;
        for (int i = 0; i < ENTRIES; i++) begin
            st_d[i]    = st_q[i];
            op_d[i]    = op_q[i];
            depa_d[i]  = depa_q[i];
            depb_d[i]  = depb_q[i];
            dataa_d[i] = dataa_q[i];
            datab_d[i] = datab_q[i];
            unique case (st_q[i])
                S_FREE: begin
                    if (issue_fire && free_oh[i]) begin
                        op_d[i]    = issue_op;
                        depa_d[i]  = in_depa;
                        depb_d[i]  = in_depb;
                        dataa_d[i] = in_dataa;
                        datab_d[i] = in_datab;
                        st_d[i]    = (in_depa != '0 || in_depb != '0)
                                   ? S_WAIT : S_READY;
                    end
                end
                S_WAIT: begin
                    if (cdb_hit && depa_q[i] == cdb_tag) begin
                        depa_d[i]  = '0;
                        dataa_d[i] = cdb_data;
                    end
                    if (cdb_hit && depb_q[i] == cdb_tag) begin
                        depb_d[i]  = '0;
                        datab_d[i] = cdb_data;
                    end
                    if (depa_d[i] == '0 && depb_d[i] == '0) begin
                        st_d[i] = S_READY;
                    end
                end
                S_READY: begin
                    if (load && rdy_oh[i]) begin
                        st_d[i] = S_SENT;
                    end
                end
                S_SENT: begin
                    if (cdb_hit && cdb_tag == TAG_W'(RS_BASE_TAG + i)) begin
                        st_d[i] = S_FREE;
                    end
                end
            endcase
            if (load && rdy_oh[i]) begin
                eop_d  = op_q[i];
                ea_d   = dataa_q[i];
                eb_d   = datab_q[i];
                etag_d = TAG_W'(RS_BASE_TAG + i);
            end
        end
        if (load) begin
            ev_d = any_rdy;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < ENTRIES; i++) begin
                st_q[i]    <= S_FREE;
                op_q[i]    <= '0;
                depa_q[i]  <= '0;
                depb_q[i]  <= '0;
                dataa_q[i] <= '0;
                datab_q[i] <= '0;
            end
            ev_q   <= 1'b0;
            eop_q  <= '0;
            ea_q   <= '0;
            eb_q   <= '0;
            etag_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                st_q[i]    <= st_d[i];
                op_q[i]    <= op_d[i];
                depa_q[i]  <= depa_d[i];
                depb_q[i]  <= depb_d[i];
                dataa_q[i] <= dataa_d[i];
                datab_q[i] <= datab_d[i];
            end
            ev_q   <= ev_d;
            eop_q  <= eop_d;
            ea_q   <= ea_d;
            eb_q   <= eb_d;
            etag_q <= etag_d;
        end
    end

    assign issue_ready = any_free;
    assign issue_tag   = any_free ? free_tag : '0;
    assign busy_count  = cnt;
    assign exec_valid  = ev_q;
    assign exec_op     = eop_q;
    assign exec_a      = ea_q;
    assign exec_b      = eb_q;
    assign exec_tag    = etag_q;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed cycle table, CLR corner case, then
// random traffic checked against a tag-pool model of the station.
module tb_reservation_station;
    localparam int DW = 16;
    localparam int TW = 3;
    localparam int NE = 2;
    localparam int BT = 1;

    logic          CLK = 1'b0;
    logic          CLR = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [2:0]    issue_op = '0;
    logic [TW-1:0] issue_depA = '0;
    logic [DW-1:0] issue_dataA = '0;
    logic [TW-1:0] issue_depB = '0;
    logic [DW-1:0] issue_dataB = '0;
    logic [TW-1:0] issue_tag;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [DW-1:0] cdb_data = '0;
    logic          exec_valid;
    logic          exec_ready = 1'b0;
    logic [2:0]    exec_op;
    logic [DW-1:0] exec_a;
    logic [DW-1:0] exec_b;
    logic [TW-1:0] exec_tag;
    logic [2:0]    busy_count;

    always #5 CLK = ~CLK;

    reservation_station #(
        .DATA_W(DW), .TAG_W(TW), .ENTRIES(NE), .RS_BASE_TAG(BT)
    ) dut (
        .CLK(CLK), .CLR(CLR),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op),
        .issue_depA(issue_depA), .issue_dataA(issue_dataA),
        .issue_depB(issue_depB), .issue_dataB(issue_dataB),
        .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .exec_valid(exec_valid), .exec_ready(exec_ready),
        .exec_op(exec_op), .exec_a(exec_a), .exec_b(exec_b),
        .exec_tag(exec_tag), .busy_count(busy_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic          iv;
        logic [2:0]    op;
        logic [TW-1:0] da;
        logic [DW-1:0] a;
        logic [TW-1:0] db;
        logic [DW-1:0] b;
        logic          cv;
        logic [TW-1:0] ct;
        logic [DW-1:0] cd;
        logic          er;
        logic          x_ir;
        logic [TW-1:0] x_it;
        logic          x_ev;
        logic [TW-1:0] x_et;
        logic [2:0]    x_eo;
        logic [DW-1:0] x_ea;
        logic [DW-1:0] x_eb;
        logic [2:0]    x_bc;
    } vec_t;

    function automatic vec_t V(
        input int iv, input int op, input int da, input int a,
        input int db, input int b, input int cv, input int ct,
        input int cd, input int er, input int ir, input int it,
        input int ev, input int et, input int eo, input int ea,
        input int eb, input int bc);
        vec_t v;
        v.iv = 1'(iv);   v.op = 3'(op);   v.da = TW'(da);
        v.a  = DW'(a);   v.db = TW'(db);  v.b  = DW'(b);
        v.cv = 1'(cv);   v.ct = TW'(ct);  v.cd = DW'(cd);
        v.er = 1'(er);   v.x_ir = 1'(ir); v.x_it = TW'(it);
        v.x_ev = 1'(ev); v.x_et = TW'(et); v.x_eo = 3'(eo);
        v.x_ea = DW'(ea); v.x_eb = DW'(eb); v.x_bc = 3'(bc);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_op = v.op;
        issue_depA = v.da;  issue_dataA = v.a;
        issue_depB = v.db;  issue_dataB = v.b;
        cdb_valid = v.cv;   cdb_tag = v.ct; cdb_data = v.cd;
        exec_ready = v.er;
    endtask

    // Model: one slot per tag owner; an op is ready once it holds both values.
    logic          m_used [NE];
    logic          m_sent [NE];
    logic [2:0]    m_op   [NE];
    logic [TW-1:0] m_ta   [NE];
    logic [TW-1:0] m_tb   [NE];
    logic [DW-1:0] m_a    [NE];
    logic [DW-1:0] m_b    [NE];
    logic          m_ev;
    logic [2:0]    m_eop;
    logic [DW-1:0] m_ea, m_eb;
    logic [TW-1:0] m_etag;

    task automatic m_reset();
        for (int e = 0; e < NE; e++) begin
            m_used[e] = 0; m_sent[e] = 0; m_op[e] = 0;
            m_ta[e] = 0; m_tb[e] = 0; m_a[e] = 0; m_b[e] = 0;
        end
        m_ev = 0; m_eop = 0; m_ea = 0; m_eb = 0; m_etag = 0;
    endtask

    function automatic int m_first_free();
        for (int e = 0; e < NE; e++) if (!m_used[e]) return e;
        return -1;
    endfunction

    function automatic int m_first_ready();
        for (int e = 0; e < NE; e++)
            if (m_used[e] && !m_sent[e] && m_ta[e] == 0 && m_tb[e] == 0)
                return e;
        return -1;
    endfunction

    task automatic m_check();
        int f;
        int cnt;
        f = m_first_free();
        cnt = 0;
        for (int e = 0; e < NE; e++) if (m_used[e]) cnt++;
        chk("rnd issue_ready", 32'(issue_ready), 32'(f >= 0));
        chk("rnd issue_tag", 32'(issue_tag), (f >= 0) ? 32'(f + BT) : 0);
        chk("rnd busy_count", 32'(busy_count), 32'(cnt));
        chk("rnd exec_valid", 32'(exec_valid), 32'(m_ev));
        if (m_ev) begin
            chk("rnd exec_tag", 32'(exec_tag), 32'(m_etag));
            chk("rnd exec_op", 32'(exec_op), 32'(m_eop));
            chk("rnd exec_a", 32'(exec_a), 32'(m_ea));
            chk("rnd exec_b", 32'(exec_b), 32'(m_eb));
        end
    endtask

    task automatic m_step();
        int  f, r;
        logic rel [NE];
        logic hit;
        f = m_first_free();
        r = m_first_ready();
        hit = cdb_valid && cdb_tag != 0;
        for (int e = 0; e < NE; e++)
            rel[e] = m_used[e] && m_sent[e] && hit && cdb_tag == TW'(e + BT);
        for (int e = 0; e < NE; e++) begin
            if (m_used[e] && !m_sent[e] && hit) begin
                if (m_ta[e] == cdb_tag) begin m_ta[e] = 0; m_a[e] = cdb_data; end
                if (m_tb[e] == cdb_tag) begin m_tb[e] = 0; m_b[e] = cdb_data; end
            end
        end
        if (!m_ev || exec_ready) begin
            m_ev = (r >= 0);
            if (r >= 0) begin
                m_eop = m_op[r]; m_ea = m_a[r]; m_eb = m_b[r];
                m_etag = TW'(r + BT);
                m_sent[r] = 1;
            end
        end
        if (issue_valid && f >= 0) begin
            m_used[f] = 1; m_sent[f] = 0; m_op[f] = issue_op;
            m_ta[f] = issue_depA; m_a[f] = issue_dataA;
            m_tb[f] = issue_depB; m_b[f] = issue_dataB;
            if (hit && cdb_tag == issue_depA) begin m_ta[f] = 0; m_a[f] = cdb_data; end
            if (hit && cdb_tag == issue_depB) begin m_tb[f] = 0; m_b[f] = cdb_data; end
        end
        for (int e = 0; e < NE; e++)
            if (rel[e]) begin m_used[e] = 0; m_sent[e] = 0; end
    endtask

    vec_t tv [31];
    vec_t idle;

    initial begin
        // iv op da a db b | cv ct cd | er || ir it ev et eo ea eb bc
        tv[0]  = V(1,2,0,5,0,7,           0,0,0,    1, 1,1,0,0,0,0,0,0);
        tv[1]  = V(0,0,0,0,0,0,           0,0,0,    1, 1,2,0,0,0,0,0,1);
        tv[2]  = V(0,0,0,0,0,0,           1,1,'h1234,1, 1,2,1,1,2,5,7,1);
        tv[3]  = V(1,1,3,'h1234,0,'h11,   0,0,0,    1, 1,1,0,0,0,0,0,0);
        tv[4]  = V(0,0,0,0,0,0,           0,0,0,    1, 1,2,0,0,0,0,0,1);
        tv[5]  = V(0,0,0,0,0,0,           0,0,0,    1, 1,2,0,0,0,0,0,1);
        tv[6]  = V(0,0,0,0,0,0,           1,3,'hAA, 1, 1,2,0,0,0,0,0,1);
        tv[7]  = V(0,0,0,0,0,0,           0,0,0,    1, 1,2,0,0,0,0,0,1);
        tv[8]  = V(0,0,0,0,0,0,           1,1,0,    1, 1,2,1,1,1,'hAA,'h11,1);
        tv[9]  = V(1,3,4,0,0,2,           1,4,9,    1, 1,1,0,0,0,0,0,0);
        tv[10] = V(0,0,0,0,0,0,           0,0,0,    1, 1,2,0,0,0,0,0,1);
        tv[11] = V(0,0,0,0,0,0,           1,1,0,    1, 1,2,1,1,3,9,2,1);
        tv[12] = V(1,4,5,0,0,'h10,        0,0,0,    1, 1,1,0,0,0,0,0,0);
        tv[13] = V(1,5,6,0,0,'h20,        0,0,0,    1, 1,2,0,0,0,0,0,1);
        tv[14] = V(1,6,0,1,0,1,           0,0,0,    1, 0,0,0,0,0,0,0,2);
        tv[15] = V(1,6,0,1,0,1,           1,6,'h66, 1, 0,0,0,0,0,0,0,2);
        tv[16] = V(1,6,0,1,0,1,           0,0,0,    1, 0,0,0,0,0,0,0,2);
        tv[17] = V(1,6,0,1,0,1,           1,2,0,    1, 0,0,1,2,5,'h66,'h20,2);
        tv[18] = V(0,0,0,0,0,0,           1,5,'h55, 1, 1,2,0,0,0,0,0,1);
        tv[19] = V(0,0,0,0,0,0,           0,0,0,    1, 1,2,0,0,0,0,0,1);
        tv[20] = V(0,0,0,0,0,0,           1,1,0,    1, 1,2,1,1,4,'h55,'h10,1);
        tv[21] = V(1,1,0,'hA1,0,'hB1,     0,0,0,    0, 1,1,0,0,0,0,0,0);
        tv[22] = V(1,2,0,'hA2,0,'hB2,     0,0,0,    0, 1,2,0,0,0,0,0,1);
        tv[23] = V(0,0,0,0,0,0,           0,0,0,    0, 0,0,1,1,1,'hA1,'hB1,2);
        tv[24] = V(0,0,0,0,0,0,           0,0,0,    0, 0,0,1,1,1,'hA1,'hB1,2);
        tv[25] = V(0,0,0,0,0,0,           0,0,0,    0, 0,0,1,1,1,'hA1,'hB1,2);
        tv[26] = V(0,0,0,0,0,0,           0,0,0,    0, 0,0,1,1,1,'hA1,'hB1,2);
        tv[27] = V(0,0,0,0,0,0,           0,0,0,    1, 0,0,1,1,1,'hA1,'hB1,2);
        tv[28] = V(0,0,0,0,0,0,           1,1,0,    1, 0,0,1,2,2,'hA2,'hB2,2);
        tv[29] = V(0,0,0,0,0,0,           1,2,0,    1, 1,1,0,0,0,0,0,1);
        tv[30] = V(0,0,0,0,0,0,           0,0,0,    1, 1,1,0,0,0,0,0,0);
        idle   = V(0,0,0,0,0,0,           0,0,0,    0, 0,0,0,0,0,0,0,0);

        @(negedge CLK);
        chk("reset exec_valid", 32'(exec_valid), 0);
        chk("reset issue_tag", 32'(issue_tag), BT);
        @(negedge CLK);
        CLR = 1'b0;

        for (int k = 0; k < 31; k++) begin
            @(negedge CLK);
            drive(tv[k]);
            chk($sformatf("vec%0d issue_ready", k), 32'(issue_ready), 32'(tv[k].x_ir));
            chk($sformatf("vec%0d issue_tag", k), 32'(issue_tag), 32'(tv[k].x_it));
            chk($sformatf("vec%0d exec_valid", k), 32'(exec_valid), 32'(tv[k].x_ev));
            chk($sformatf("vec%0d busy_count", k), 32'(busy_count), 32'(tv[k].x_bc));
            if (tv[k].x_ev) begin
                chk($sformatf("vec%0d exec_tag", k), 32'(exec_tag), 32'(tv[k].x_et));
                chk($sformatf("vec%0d exec_op", k), 32'(exec_op), 32'(tv[k].x_eo));
                chk($sformatf("vec%0d exec_a", k), 32'(exec_a), 32'(tv[k].x_ea));
                chk($sformatf("vec%0d exec_b", k), 32'(exec_b), 32'(tv[k].x_eb));
            end
        end

        // CLR with one SENT entry held in dispatch and one WAIT entry
        @(negedge CLK);
        drive(V(1,7,0,'h77,0,'h78, 0,0,0, 0, 0,0,0,0,0,0,0,0));
        @(negedge CLK);
        drive(V(1,1,7,0,0,3, 0,0,0, 0, 0,0,0,0,0,0,0,0));
        @(negedge CLK);
        drive(idle);
        chk("pre-clr exec_valid", 32'(exec_valid), 1);
        chk("pre-clr exec_a", 32'(exec_a), 'h77);
        chk("pre-clr busy_count", 32'(busy_count), 2);
        #2 CLR = 1'b1;
        #1;
        chk("clr exec_valid", 32'(exec_valid), 0);
        chk("clr exec_op", 32'(exec_op), 0);
        chk("clr exec_a", 32'(exec_a), 0);
        chk("clr exec_b", 32'(exec_b), 0);
        chk("clr exec_tag", 32'(exec_tag), 0);
        chk("clr busy_count", 32'(busy_count), 0);
        chk("clr issue_ready", 32'(issue_ready), 1);
        chk("clr issue_tag", 32'(issue_tag), BT);
        @(negedge CLK);
        CLR = 1'b0;
        m_reset();
        m_step();

        for (int k = 0; k < 600; k++) begin
            @(negedge CLK);
            m_check();
            issue_valid = 1'($urandom_range(0, 1));
            issue_op    = 3'($urandom_range(0, 7));
            issue_depA  = $urandom_range(0, 1) ? TW'($urandom_range(1, 7)) : '0;
            issue_depB  = $urandom_range(0, 1) ? TW'($urandom_range(1, 7)) : '0;
            issue_dataA = DW'($urandom);
            issue_dataB = DW'($urandom);
            cdb_valid   = 1'($urandom_range(0, 1));
            cdb_tag     = TW'($urandom_range(0, 7));
            cdb_data    = DW'($urandom);
            exec_ready  = ($urandom_range(0, 9) < 7);
            m_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
